// File: rtl/image_mask_loader.sv
// image_mask_loader: streams each captured obstacle image into the mask BRAM,
// one row per cycle, pausing while the collision phase owns the BRAM.
// A one-deep pending buffer absorbs an image arriving mid-load; further
// images are dropped and flagged.

`ifndef DEPTH
`define DEPTH 128
`endif

module image_mask_loader #(
  parameter int unsigned DEPTH     = `DEPTH,
  parameter int unsigned ROW_BITS  = 32,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MASK_BASE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                img_valid,
  input  logic [DEPTH-1:0]    img_data,
  input  logic                in_collision_state,
  output logic                mask_we,
  output logic [ADDR_W-1:0]   mask_addr,
  output logic [ROW_BITS-1:0] mask_wdata,
  output logic                load_busy,
  output logic                load_done,
  output logic                img_dropped
);

  localparam int unsigned NROWS = DEPTH / ROW_BITS;
  localparam int unsigned CNT_W = $clog2(NROWS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NROWS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DEPTH-1:0]    shadow_q, shadow_d;
  logic [DEPTH-1:0]    pending_q, pending_d;
  logic                pend_v_q, pend_v_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ROW_BITS-1:0] wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;
  logic                take_pend;

  // State, image buffers and registered BRAM/status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      pending_q <= '0;
      pend_v_q  <= 1'b0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      pend_v_q  <= pend_v_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  // Next-state, row sequencing (shadow shifts up one row per write) and pending/drop handling
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    drop_d    = 1'b0;
    take_pend = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          take_pend = 1'b1;
        end else if (img_valid) begin
          shadow_d = img_data;
          cnt_d    = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (!in_collision_state) begin
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            we_d     = 1'b1;
            addr_d   = ADDR_W'(MASK_BASE) + ADDR_W'(cnt_q);
            wdata_d  = shadow_q[DEPTH-1 -: ROW_BITS];
            shadow_d = shadow_q << ROW_BITS;
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (pend_v_q) begin
          take_pend = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_pend) begin
      shadow_d = pending_q;
      pend_v_d = 1'b0;
      cnt_d    = '0;
      state_d  = LOAD;
    end

    // A new image goes to the pending slot unless it was captured directly or the slot is full
    if (img_valid && !(state_q == IDLE && !pend_v_q)) begin
      if (!pend_v_q || take_pend) begin
        pending_d = img_data;
        pend_v_d  = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end

    busy_d = (state_d == LOAD);
  end

  assign mask_we     = we_q;
  assign mask_addr   = addr_q;
  assign mask_wdata  = wdata_q;
  assign load_busy   = busy_q;
  assign load_done   = done_q;
  assign img_dropped = drop_q;

endmodule

// File: tb/tb_image_mask_loader.sv
// Bench for image_mask_loader: cycle-exact vector table for single loads and
// collision stalls, plus hand-written pending/drop, mid-load reset and
// 96-bit geometry sequences checked against a write log.

module tb_image_mask_loader;

  localparam int unsigned ADDR_W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 128-bit instance, MASK_BASE = 0x10
  logic         rst_n;
  logic         img_valid;
  logic [127:0] img_data;
  logic         coll;
  logic         we;
  logic [9:0]   addr;
  logic [31:0]  wdata;
  logic         busy, done, drop;

  // 96-bit instance, MASK_BASE = 0x20
  logic         v96;
  logic [95:0]  d96;
  logic         we96;
  logic [9:0]   addr96;
  logic [31:0]  wdata96;
  logic         busy96, done96, drop96;

  image_mask_loader #(.DEPTH(128), .ROW_BITS(32), .ADDR_W(ADDR_W), .MASK_BASE(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .img_valid(img_valid), .img_data(img_data),
    .in_collision_state(coll), .mask_we(we), .mask_addr(addr), .mask_wdata(wdata),
    .load_busy(busy), .load_done(done), .img_dropped(drop)
  );

  image_mask_loader #(.DEPTH(96), .ROW_BITS(32), .ADDR_W(ADDR_W), .MASK_BASE(32)) u_dut96 (
    .clk(clk), .rst_n(rst_n), .img_valid(v96), .img_data(d96),
    .in_collision_state(coll), .mask_we(we96), .mask_addr(addr96), .mask_wdata(wdata96),
    .load_busy(busy96), .load_done(done96), .img_dropped(drop96)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    else passed++;
  endtask

  function automatic logic [31:0] row128(input logic [127:0] img, input int r);
    return img[127 - 32*r -: 32];
  endfunction

  function automatic logic [31:0] row96(input logic [95:0] img, input int r);
    return img[95 - 32*r -: 32];
  endfunction

  // Write log: BRAM-side view of every cycle with mask_we high
  int          cyc = 0;
  logic [9:0]  log_a[$];
  logic [31:0] log_d[$];
  int          log_c[$];
  int          n_done = 0, n_drop = 0;
  logic [9:0]  log96_a[$];
  logic [31:0] log96_d[$];
  int          log96_c[$];
  int          n_done96 = 0, done96_c = 0;

  always @(negedge clk) begin
    cyc++;
    if (we)   begin log_a.push_back(addr); log_d.push_back(wdata); log_c.push_back(cyc); end
    if (done) n_done++;
    if (drop) n_drop++;
    if (we96) begin log96_a.push_back(addr96); log96_d.push_back(wdata96); log96_c.push_back(cyc); end
    if (done96) begin n_done96++; done96_c = cyc; end
  end

  typedef struct {
    logic         rst_n, valid, coll;
    logic [127:0] data;
    logic         we;
    logic [9:0]   addr;
    logic [31:0]  wdata;
    logic         busy, done, drop, chk_ad;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic c, input logic [127:0] d,
                              input logic w, input logic [9:0] a, input logic [31:0] wd,
                              input logic b, input logic dn, input logic ck);
    vec_t t;
    t.rst_n = r; t.valid = v; t.coll = c; t.data = d;
    t.we = w; t.addr = a; t.wdata = wd; t.busy = b; t.done = dn; t.drop = 1'b0; t.chk_ad = ck;
    return t;
  endfunction

  localparam logic [127:0] IMG_A = 128'hAAAA0001_BBBB0002_CCCC0003_DDDD0004;
  localparam logic [127:0] IMG_B = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] IMG_C = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
  localparam logic [95:0]  IMG_D = 96'h01234567_89ABCDEF_FEDCBA98;

  vec_t tbl[$];
  int   base;
  int   d0, r0;

  initial begin
    rst_n = 1'b0; img_valid = 1'b0; img_data = '0; coll = 1'b0; v96 = 1'b0; d96 = '0;

    // Reset, then single load with no collision
    tbl.push_back(mk(0, 0, 0, '0,    0, 10'h000, 32'h0,        0, 0, 1));
    tbl.push_back(mk(0, 1, 0, IMG_A, 0, 10'h000, 32'h0,        0, 0, 1));
    tbl.push_back(mk(1, 1, 0, IMG_A, 0, 10'h000, 32'h0,        1, 0, 1));
    tbl.push_back(mk(1, 0, 0, '0,    1, 10'h010, 32'hAAAA0001, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, '0,    1, 10'h011, 32'hBBBB0002, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, '0,    1, 10'h012, 32'hCCCC0003, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, '0,    1, 10'h013, 32'hDDDD0004, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, '0,    0, 10'h000, 32'h0,        0, 1, 0));
    tbl.push_back(mk(1, 0, 0, '0,    0, 10'h000, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0, 0, '0,    0, 10'h000, 32'h0,        0, 0, 0));
    // Collision pause of 3 edges after row 1 is written
    tbl.push_back(mk(1, 1, 0, IMG_A, 0, 10'h000, 32'h0,        1, 0, 0));
    tbl.push_back(mk(1, 0, 0, '0,    1, 10'h010, 32'hAAAA0001, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, '0,    1, 10'h011, 32'hBBBB0002, 1, 0, 1));
    tbl.push_back(mk(1, 0, 1, '0,    0, 10'h000, 32'h0,        1, 0, 0));
    tbl.push_back(mk(1, 0, 1, '0,    0, 10'h000, 32'h0,        1, 0, 0));
    tbl.push_back(mk(1, 0, 1, '0,    0, 10'h000, 32'h0,        1, 0, 0));
    tbl.push_back(mk(1, 0, 0, '0,    1, 10'h012, 32'hCCCC0003, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, '0,    1, 10'h013, 32'hDDDD0004, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, '0,    0, 10'h000, 32'h0,        0, 1, 0));
    tbl.push_back(mk(1, 0, 0, '0,    0, 10'h000, 32'h0,        0, 0, 0));
    // Collision already high at capture, held for 5 edges
    tbl.push_back(mk(1, 1, 1, IMG_B, 0, 10'h000, 32'h0,        1, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 0, 1, '0,  0, 10'h000, 32'h0,        1, 0, 0));
    tbl.push_back(mk(1, 0, 0, '0,    1, 10'h010, 32'h11112222, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, '0,    1, 10'h011, 32'h33334444, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, '0,    1, 10'h012, 32'h55556666, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, '0,    1, 10'h013, 32'h77778888, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, '0,    0, 10'h000, 32'h0,        0, 1, 0));
    tbl.push_back(mk(1, 0, 0, '0,    0, 10'h000, 32'h0,        0, 0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; img_valid = tbl[i].valid; coll = tbl[i].coll; img_data = tbl[i].data;
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i),   we,   tbl[i].we);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("v%0d_done", i), done, tbl[i].done);
      chk($sformatf("v%0d_drop", i), drop, tbl[i].drop);
      if (tbl[i].chk_ad) begin
        chk($sformatf("v%0d_addr", i),  addr,  tbl[i].addr);
        chk($sformatf("v%0d_wdata", i), wdata, tbl[i].wdata);
      end
    end

    // Pending and drop: A, B, C two cycles apart
    @(negedge clk);
    img_valid = 1'b0; coll = 1'b0;
    base = log_a.size(); d0 = n_done; r0 = n_drop;
    @(negedge clk); img_valid = 1'b1; img_data = IMG_A;
    @(negedge clk); img_valid = 1'b0;
    @(negedge clk); img_valid = 1'b1; img_data = IMG_B;
    @(negedge clk); img_valid = 1'b0;
    @(negedge clk); img_valid = 1'b1; img_data = IMG_C;
    @(posedge clk); #1;
    chk("drop_pulse", drop, 1'b1);
    @(negedge clk); img_valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("pd_nwrites", log_a.size() - base, 8);
    if (log_a.size() >= base + 8) begin
      for (int r = 0; r < 4; r++) begin
        chk($sformatf("pd_a_addr%0d", r), log_a[base+r],   10'h010 + 10'(r));
        chk($sformatf("pd_a_data%0d", r), log_d[base+r],   row128(IMG_A, r));
        chk($sformatf("pd_b_addr%0d", r), log_a[base+4+r], 10'h010 + 10'(r));
        chk($sformatf("pd_b_data%0d", r), log_d[base+4+r], row128(IMG_B, r));
      end
      chk("pd_consecutive_a", log_c[base+3] - log_c[base], 3);
      chk("pd_gap_a_to_b",    log_c[base+4] - log_c[base+3], 3);
    end
    chk("pd_ndone", n_done - d0, 2);
    chk("pd_ndrop", n_drop - r0, 1);
    chk("pd_idle",  busy, 1'b0);

    // Reset mid-load after row 1 with B pending
    base = log_a.size();
    @(negedge clk); img_valid = 1'b1; img_data = IMG_A;
    @(negedge clk); img_valid = 1'b0;
    @(negedge clk); img_valid = 1'b1; img_data = IMG_B;
    @(negedge clk); img_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_we",    we,    1'b0);
    chk("rst_addr",  addr,  10'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_done",  done,  1'b0);
    chk("rst_drop",  drop,  1'b0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_partial_rows", log_a.size() - base, 2);
    img_valid = 1'b1; img_data = IMG_C;
    @(negedge clk); img_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_new_nwrites", log_a.size() - base, 6);
    if (log_a.size() >= base + 6) begin
      for (int r = 0; r < 4; r++) begin
        chk($sformatf("rst_c_addr%0d", r), log_a[base+2+r], 10'h010 + 10'(r));
        chk($sformatf("rst_c_data%0d", r), log_d[base+2+r], row128(IMG_C, r));
      end
    end

    // 96-bit geometry: three rows, counter stops at 3
    @(negedge clk); v96 = 1'b1; d96 = IMG_D;
    @(negedge clk); v96 = 1'b0;
    repeat (12) @(negedge clk);
    chk("g96_nwrites", log96_a.size(), 3);
    if (log96_a.size() >= 3) begin
      for (int r = 0; r < 3; r++) begin
        chk($sformatf("g96_addr%0d", r), log96_a[r], 10'h020 + 10'(r));
        chk($sformatf("g96_data%0d", r), log96_d[r], row96(IMG_D, r));
      end
      chk("g96_done_timing", done96_c - log96_c[2], 1);
    end
    chk("g96_ndone", n_done96, 1);
    chk("g96_idle",  busy96, 1'b0);
    chk("g96_nodrop", drop96, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

endmodule
